game_rate_detect: RTL

- Companion to the game clock divider: recovers the divider's rate selection by watching `clk_game` from the fast system-clock side.
- Synchronises `clk_game` into the `clk` domain and measures the spacing between its toggles.
- Classifies that spacing back into the 2-bit rate code, with lock, timeout and error reporting.
- Also emits a one-cycle `tick` per rising `clk_game` edge. Game logic uses `tick` instead of clocking on `clk_game`.

---
 rtl/game_rate_detect.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/game_rate_detect.sv
// Recovers the game clock divider's 2-bit rate code from clk_game toggle spacing, plus a tick per rising edge.
// Latency: tick and all status outputs are 3 clk edges after clk_game changes; no backpressure, pure monitor.
module game_rate_detect #(
  parameter int BASE = 12500000,
  parameter int TOL  = 2,
  parameter int CW   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_game,
  output logic       tick,
  output logic [1:0] rate_code,
  output logic       rate_valid,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // One count past the longest acceptable interval, so a valid code-3 interval never times out.
  localparam logic [CW-1:0] TMO_CNT = CW'(8 * BASE + TOL + 2);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic          s1, s2, s3;
  logic          ev, rise;
  logic [CW-1:0] cnt;
  state_t        state, state_nxt;
  logic [1:0]    cand, cand_nxt;
  logic          cand_vld, cand_vld_nxt;
  logic [1:0]    code_nxt;
  logic          err_nxt;
  logic          cls_hit;
  logic [1:0]    cls_code;
  logic          tmo;

  function automatic logic [2:0] classify(input logic [CW-1:0] ival);
    logic [2:0]    res;
    logic [CW-1:0] nom;
    res = 3'b000;
    for (int c = 0; c < 4; c++) begin
      nom = CW'(BASE * (1 << c) + 1);
      if ((ival >= nom - CW'(TOL)) && (ival <= nom + CW'(TOL))) begin
        res = {1'b1, 2'(c)};
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_game;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign ev   = s2 ^ s3;
  assign rise = s2 & ~s3;

  // The count seen on an event cycle is the distance from the previous event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (ev) begin
      cnt <= CW'(1);
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign {cls_hit, cls_code} = classify(cnt);
  assign tmo = (state != IDLE) && (cnt == TMO_CNT) && !ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ev) state_nxt = ACQ;
      end
      ACQ: begin
        if (ev) begin
          if (cls_hit && cand_vld && (cand == cls_code)) state_nxt = LOCK;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      LOCK: begin
        if (ev) begin
          if (!cls_hit || (cls_code != rate_code)) state_nxt = ACQ;
        end else if (tmo) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    err_nxt      = 1'b0;
    cand_nxt     = cand;
    cand_vld_nxt = cand_vld;
    code_nxt     = rate_code;
    case (state)
      IDLE: begin
        if (ev) cand_vld_nxt = 1'b0;
      end
      ACQ: begin
        if (ev) begin
          if (cls_hit) begin
            if (cand_vld && (cand == cls_code)) begin
              code_nxt = cls_code;
            end else begin
              cand_nxt     = cls_code;
              cand_vld_nxt = 1'b1;
            end
          end else begin
            err_nxt      = 1'b1;
            cand_vld_nxt = 1'b0;
          end
        end else if (tmo) begin
          err_nxt      = 1'b1;
          cand_vld_nxt = 1'b0;
        end
      end
      LOCK: begin
        if (ev) begin
          if (cls_hit) begin
            // A clean switch to another rate seeds the candidate without flagging an error.
            if (cls_code != rate_code) begin
              cand_nxt     = cls_code;
              cand_vld_nxt = 1'b1;
            end
          end else begin
            err_nxt      = 1'b1;
            cand_vld_nxt = 1'b0;
          end
        end else if (tmo) begin
          err_nxt      = 1'b1;
          cand_vld_nxt = 1'b0;
        end
      end
      default: begin
        cand_vld_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= 2'd0;
      cand_vld  <= 1'b0;
      rate_code <= 2'd0;
      err       <= 1'b0;
      tick      <= 1'b0;
    end else begin
      cand      <= cand_nxt;
      cand_vld  <= cand_vld_nxt;
      rate_code <= code_nxt;
      err       <= err_nxt;
      tick      <= rise;
    end
  end

  assign rate_valid = (state == LOCK);

endmodule
